division_unit: RTL
==================

# division_unit

Iterative radix-2 integer divider for the RV32M division instructions DIV, DIVU, REM and REMU. It sits in the integer execution unit (ITU) beside the multiplier and consumes the `div_uop_t` opcode that the decoder places in the ITU `DIV` sub-union. Each operation is a fixed-latency, non-pipelined sequence. The result is returned with the instruction tag that was issued with it.

## Interface
- `TAG_WIDTH`, 6: width of the instruction tag carried through the unit.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  abort the operation in flight.
- `data_valid_i`  in  1  operands and opcode valid; sampled only while `idle_o` is high.
- `dividend_i`  in  32  rs1.
- `divisor_i`  in  32  rs2.
- `operation_i`  in  2  `div_uop_t` (DIV, DIVU, REM, REMU).
- `tag_i`  in  TAG_WIDTH  instruction tag.
- `result_o`  out  32  quotient or remainder (registered).
- `tag_o`  out  TAG_WIDTH  tag of `result_o` (registered).
- `data_valid_o`  out  1  one-cycle result strobe (registered).
- `idle_o`  out  1  unit can accept an operation this cycle.

## Operation
- States are IDLE, PREPARE, DIVIDE and RESTORE. `idle_o` is high if and only if the state is IDLE.
- **Accept:** `data_valid_i && idle_o && !flush_i` latches the operands, opcode and tag, then moves to PREPARE. While the unit is busy, `data_valid_i` is ignored. Upstream must qualify its issue with `idle_o`.
- **PREPARE:**
  - For DIV and REM, take the absolute value of both operands. Record the quotient sign as `sign(a) ^ sign(b)` and the remainder sign as `sign(a)`.
  - For DIVU and REMU, no sign handling is applied.
  - Clear the partial remainder and load the 5-bit counter with 31.
  - Special cases are resolved here and the FSM goes straight to IDLE, writing the outputs:
    - divisor == 0: quotient = 0xFFFFFFFF and remainder = dividend, for all four ops.
    - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000 and remainder = 0.
- **DIVIDE:** restoring division, one bit per cycle.
  - Each cycle: shift the remainder and dividend left by 1, then form a 33-bit trial subtraction `{rem} - {1'b0, divisor}`.
  - If the subtraction does not borrow, keep the difference and set quotient bit = 1. Otherwise set it to 0.
  - The counter decrements each cycle. At counter == 0 the FSM goes to RESTORE, giving 32 iterations in total.
- **RESTORE:** negate the quotient or remainder according to the recorded signs. Select the quotient for DIV/DIVU and the remainder for REM/REMU. Write `result_o` and `tag_o`, pulse `data_valid_o`, and return to IDLE.
- **Flush:** `flush_i` in any state forces IDLE at the next edge. The pending output is suppressed and `data_valid_o` stays 0. `flush_i` has priority over an accept in the same cycle. A flush arriving in RESTORE also suppresses the strobe.
- **Reset:** the asynchronous `rst_i` forces IDLE at any point, including mid-operation. Reset values: `result_o` = 0, `tag_o` = 0, `data_valid_o` = 0, `idle_o` = 1, counter = 0, all internal registers = 0.

## Timing
- Acceptance cycle = C0.
- **Normal path:** PREPARE in C1, DIVIDE in C2–C33, RESTORE in C34. `data_valid_o` = 1 in C35 only, with `idle_o` = 1 in C35.
- **Special case:** `data_valid_o` = 1 in C2 only.
- Back-to-back issue: a new operation may be accepted in the same cycle `data_valid_o` is high. Peak throughput is one operation per 35 cycles.
- `data_valid_o` is never high for two consecutive cycles.
- Outputs hold their last value when `data_valid_o` = 0.

## Structure
- `div_uop_t` already exists in the operations package and is reused.
- Add `localparam DIV_LATENCY = 35` to the shared package so the ITU scheduler can reserve the writeback slot.
- The FSM state enum stays local to the module.
- No sub-module: the datapath is one subtractor plus shift registers. The sign fix is a shared two's-complement negation reused for the PREPARE absolute values and for RESTORE.

## Test plan
- DIVU 100 / 7 at C0 -> `result_o` = 14 in C35, `tag_o` echoes the input, `idle_o` is high in C35. REMU with the same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
- DIV 5 / 0 -> 0xFFFFFFFF in C2. REMU 5 / 0 -> 5 in C2.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in C2. REM with the same operands -> 0.
- `flush_i` in C10 -> no `data_valid_o`, `idle_o` = 1 in C11. DIVU 9 / 3 accepted in C11 -> 3 in C46. `flush_i` together with `data_valid_i` in an IDLE cycle -> no accept.
- `rst_i` pulsed asynchronously in C20 -> all outputs take their reset values immediately and no strobe follows. Issue two operations back-to-back, the second accepted in C35 -> both results are correct and strobed in C35 and C70.

Source files
------------

// File: rtl/division_unit_pkg.sv
// ---------------------------------------------------------------------------
// division_unit_pkg
// Shared definitions for the integer execution unit's divider.
//   div_uop_t    : division micro-op selected by the decoder (DIV/DIVU/REM/REMU)
//   DIV_LATENCY  : cycles from acceptance to the result strobe on the normal
//                  path, used by the ITU scheduler to reserve a writeback slot
//   twosNegate   : two's-complement negation shared by the operand absolute
//                  value and the final sign fix
// ---------------------------------------------------------------------------
package division_unit_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_uop_t;

    localparam int DIV_LATENCY = 35;
    localparam int DIV_WIDTH   = 32;

    function automatic logic [DIV_WIDTH-1:0] twosNegate(input logic [DIV_WIDTH-1:0] value);
        return ~value + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic isSignedOp(input div_uop_t op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic isRemOp(input div_uop_t op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/division_unit.sv
// ---------------------------------------------------------------------------
// division_unit
// Iterative radix-2 restoring divider for RV32M DIV, DIVU, REM and REMU.
// One operation at a time: PREPARE (sign strip / special cases), 32 DIVIDE
// iterations, RESTORE (sign fix and result select), then back to IDLE.
//
// Ports
//   clk_i         in   clock
//   rst_i         in   asynchronous active-high reset
//   flush_i       in   abort the operation in flight, suppresses its result
//   data_valid_i  in   operands/opcode/tag valid, sampled only while idle
//   dividend_i    in   rs1
//   divisor_i     in   rs2
//   operation_i   in   div_uop_t opcode
//   tag_i         in   instruction tag
//   result_o      out  quotient or remainder (registered)
//   tag_o         out  tag belonging to result_o (registered)
//   data_valid_o  out  one-cycle result strobe (registered)
//   idle_o        out  unit can accept an operation this cycle
// ---------------------------------------------------------------------------
module division_unit
    import division_unit_pkg::*;
#(
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 data_valid_i,
    input  logic [31:0]          dividend_i,
    input  logic [31:0]          divisor_i,
    input  logic [1:0]           operation_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic [31:0]          result_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 data_valid_o,
    output logic                 idle_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREPARE,
        S_DIVIDE,
        S_RESTORE
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;

    // r_dividend shifts left each iteration and collects quotient bits in
    // its low end, so after 32 iterations it holds the quotient.
    logic [31:0]            r_dividend;
    logic [31:0]            r_divisor;
    logic [31:0]            r_rem;
    logic [4:0]             r_counter;
    div_uop_t               r_op;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   r_quotSign;
    logic                   r_remSign;

    logic [31:0]            r_result;
    logic [TAG_WIDTH-1:0]   r_tagOut;
    logic                   r_validOut;

    logic                   w_accept;
    logic                   w_signedOp;
    logic                   w_remOp;
    logic                   w_divByZero;
    logic                   w_overflow;
    logic                   w_special;
    logic [31:0]            w_specialResult;
    logic [31:0]            w_absDividend;
    logic [31:0]            w_absDivisor;
    logic [32:0]            w_shifted;
    logic [32:0]            w_trial;
    logic                   w_borrow;
    logic [31:0]            w_remNext;
    logic [31:0]            w_quotFinal;
    logic [31:0]            w_remFinal;

    assign idle_o       = (r_state == S_IDLE);
    assign result_o     = r_result;
    assign tag_o        = r_tagOut;
    assign data_valid_o = r_validOut;

    assign w_accept   = data_valid_i && idle_o && !flush_i;
    assign w_signedOp = isSignedOp(r_op);
    assign w_remOp    = isRemOp(r_op);

    // Special cases are judged on the raw latched operands so that the
    // divide-by-zero remainder returns the dividend exactly as issued.
    assign w_divByZero = (r_divisor == 32'd0);
    assign w_overflow  = w_signedOp && (r_dividend == 32'h8000_0000)
                         && (r_divisor == 32'hFFFF_FFFF);
    assign w_special   = w_divByZero || w_overflow;

    always_comb begin
        w_specialResult = 32'd0;
        if (w_divByZero) begin
            w_specialResult = w_remOp ? r_dividend : 32'hFFFF_FFFF;
        end else if (w_overflow) begin
            w_specialResult = w_remOp ? 32'd0 : 32'h8000_0000;
        end
    end

    // The absolute value of 0x80000000 stays 0x80000000, which is the
    // correct magnitude when read as unsigned by the iteration.
    assign w_absDividend = (w_signedOp && r_dividend[31]) ? twosNegate(r_dividend) : r_dividend;
    assign w_absDivisor  = (w_signedOp && r_divisor[31])  ? twosNegate(r_divisor)  : r_divisor;

    // The partial remainder is always below the divisor, so the shifted
    // value is below twice the divisor.  A non-borrowing result therefore
    // fits in 32 bits and a borrowing one always wraps into bit 32, which
    // makes bit 32 of the 33-bit difference the borrow flag.
    assign w_shifted = {r_rem, r_dividend[31]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};
    assign w_borrow  = w_trial[32];
    assign w_remNext = w_borrow ? w_shifted[31:0] : w_trial[31:0];

    assign w_quotFinal = r_quotSign ? twosNegate(r_dividend) : r_dividend;
    assign w_remFinal  = r_remSign  ? twosNegate(r_rem)      : r_rem;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; a flush overrides every transition, including an
    // accept in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stateNext = S_PREPARE;
                end
            end
            S_PREPARE: begin
                w_stateNext = w_special ? S_IDLE : S_DIVIDE;
            end
            S_DIVIDE: begin
                if (r_counter == 5'd0) begin
                    w_stateNext = S_RESTORE;
                end
            end
            S_RESTORE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
        if (flush_i) begin
            w_stateNext = S_IDLE;
        end
    end

    // Datapath and output registers.  The strobe defaults low every cycle so
    // it can never stay high for two cycles; result and tag hold otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
            r_rem      <= 32'd0;
            r_counter  <= 5'd0;
            r_op       <= DIV_OP_DIV;
            r_tag      <= '0;
            r_quotSign <= 1'b0;
            r_remSign  <= 1'b0;
            r_result   <= 32'd0;
            r_tagOut   <= '0;
            r_validOut <= 1'b0;
        end else begin
            r_validOut <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dividend <= dividend_i;
                        r_divisor  <= divisor_i;
                        r_op       <= div_uop_t'(operation_i);
                        r_tag      <= tag_i;
                    end
                end
                S_PREPARE: begin
                    r_rem      <= 32'd0;
                    r_counter  <= 5'd31;
                    r_dividend <= w_absDividend;
                    r_divisor  <= w_absDivisor;
                    r_quotSign <= w_signedOp && (r_dividend[31] ^ r_divisor[31]);
                    r_remSign  <= w_signedOp && r_dividend[31];
                    if (w_special && !flush_i) begin
                        r_result   <= w_specialResult;
                        r_tagOut   <= r_tag;
                        r_validOut <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    r_rem      <= w_remNext;
                    r_dividend <= {r_dividend[30:0], ~w_borrow};
                    r_counter  <= r_counter - 5'd1;
                end
                S_RESTORE: begin
                    if (!flush_i) begin
                        r_result   <= w_remOp ? w_remFinal : w_quotFinal;
                        r_tagOut   <= r_tag;
                        r_validOut <= 1'b1;
                    end
                end
                default: begin
                    r_counter <= 5'd0;
                end
            endcase
        end
    end

endmodule
